// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths, sizes and word/index types for the CPU
//                general-purpose register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int          REG_ADDR_W = 5;
    localparam int          REG_DATA_W = 32;
    localparam int          REG_NUM    = 32;
    localparam logic [4:0]  ZERO_REG   = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_word_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_rd_dcd_en.sv
`default_nettype none
// ============================================================================
//  Module      : dcd_en
//  Description : One-hot write-enable decoder. Index 0 has no storage behind
//                it, so the decoder leaves its output undefined when asked to
//                enable index 0; callers gate the enable before it gets here.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcd_en #(
    parameter int ADDR_W = 5
) (
    input  logic                     i_en,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic [(2**ADDR_W)-1:0]   o_onehot
);

    // Decode the index into a single enable bit; index 0 is not a legal target.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            if (i_addr == '0) begin
                o_onehot = 'x;
            end else begin
                o_onehot[i_addr] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_rd.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_rd
//  Description : General-purpose register file with one write port and two
//                registered read ports (1-cycle latency). Register 0 is
//                hard-wired to zero; optional same-edge write forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_rd
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              ReadEn,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              ReadValid
);

    localparam int          c_NUM_REGS = (ADDR_W == REG_ADDR_W) ? REG_NUM : (2**ADDR_W);
    localparam logic [ADDR_W-1:0] c_ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]      r_regFile [c_NUM_REGS];
    logic                   w_wrStrobe;
    logic [c_NUM_REGS-1:0]  w_wrOnehot;
    logic [DATA_W-1:0]      w_rdData1;
    logic [DATA_W-1:0]      w_rdData2;

    // Writes to index 0 are dropped here so the decoder never sees them.
    assign w_wrStrobe = RegWrite && (WriteRegister != c_ZERO_IDX);

    dcd_en #(
        .ADDR_W   (ADDR_W)
    ) u_dcd_en (
        .i_en     (w_wrStrobe),
        .i_addr   (WriteRegister),
        .o_onehot (w_wrOnehot)
    );

    // Storage: entry 0 is only ever reset, the rest load on their one-hot strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regFile[i] <= '0;
            end
        end else begin
            for (int i = 1; i < c_NUM_REGS; i++) begin
                if (w_wrOnehot[i]) begin
                    r_regFile[i] <= WriteData;
                end
            end
        end
    end

    // Read selection: stored value, optionally overridden by a same-edge write,
    // and always zero for index 0.
    always_comb begin
        w_rdData1 = r_regFile[ReadRegister1];
        w_rdData2 = r_regFile[ReadRegister2];
        if (BYPASS && w_wrStrobe && (WriteRegister == ReadRegister1)) begin
            w_rdData1 = WriteData;
        end
        if (BYPASS && w_wrStrobe && (WriteRegister == ReadRegister2)) begin
            w_rdData2 = WriteData;
        end
        if (ReadRegister1 == c_ZERO_IDX) begin
            w_rdData1 = '0;
        end
        if (ReadRegister2 == c_ZERO_IDX) begin
            w_rdData2 = '0;
        end
    end

    // Output stage: capture on ReadEn, hold data otherwise, valid follows ReadEn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData1 <= '0;
            ReadData2 <= '0;
            ReadValid <= 1'b0;
        end else begin
            ReadValid <= ReadEn;
            if (ReadEn) begin
                ReadData1 <= w_rdData1;
                ReadData2 <= w_rdData2;
            end
        end
    end

endmodule
`default_nettype wire
